// File: rtl/fun_pow_root_if.sv
// Start/busy/done handshake bundle for the fun_pow_root evaluator.
// The result width follows the operand width so both ends always agree.
interface fun_pow_root_if #(
  parameter int WIDTH = 8
);
  localparam int Y_W = (3 * WIDTH + 2) / 2;

  logic             start_i;
  logic             mode_i;
  logic [WIDTH-1:0] a_bi;
  logic [WIDTH-1:0] b_bi;
  logic             busy_o;
  logic             done_o;
  logic [Y_W-1:0]   y_bo;

  modport master (
    output start_i, mode_i, a_bi, b_bi,
    input  busy_o, done_o, y_bo
  );

  modport slave (
    input  start_i, mode_i, a_bi, b_bi,
    output busy_o, done_o, y_bo
  );
endinterface

// File: rtl/fun_pow_root.sv
// Sequential y = floor(sqrt(a + b^P)), P = 3 (mode 0) or P = 2 (mode 1).
// Shift-add multiplier and restoring bit-pair square root share one FSM.
module fun_pow_root #(
  parameter int WIDTH = 8
) (
  input logic           clk_i,
  input logic           rst_i,
  fun_pow_root_if.slave bus
);
  localparam int SUM_W  = 3 * WIDTH + 1;
  localparam int Y_W    = (SUM_W + 1) / 2;
  localparam int PROD_W = 3 * WIDTH;
  localparam int RAD_W  = 2 * Y_W;
  localparam int REM_W  = Y_W + 3;
  localparam int CNT_W  = $clog2(Y_W + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL1,
    S_MUL2,
    S_ADD,
    S_SQRT
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [WIDTH-1:0]  mplr;
  logic              cube_q;
  logic [PROD_W-1:0] mcand;
  logic [PROD_W-1:0] acc;
  logic [RAD_W-1:0]  rad;
  logic [REM_W-1:0]  rem;
  logic [Y_W-1:0]    root;
  logic [CNT_W-1:0]  cnt;
  logic              busy_q;
  logic              done_q;
  logic [Y_W-1:0]    y_q;

  logic [PROD_W-1:0]      acc_nxt;
  logic [SUM_W-1:0]       sum;
  logic [REM_W+Y_W-1:0]   step;

  // One restoring iteration: bring down the next bit pair, try (2q)*2+1.
  function automatic logic [REM_W+Y_W-1:0] sqrt_step(
    input logic [REM_W-1:0] r,
    input logic [Y_W-1:0]   q,
    input logic [1:0]       pair
  );
    logic [REM_W-1:0] sh;
    logic [REM_W-1:0] trial;
    sh    = {r[REM_W-3:0], pair};
    trial = {{(REM_W-Y_W-2){1'b0}}, q, 2'b01};
    if (sh >= trial) begin
      return {sh - trial, q[Y_W-2:0], 1'b1};
    end
    return {sh, q[Y_W-2:0], 1'b0};
  endfunction

  assign acc_nxt = mplr[0] ? (acc + mcand) : acc;
  assign sum     = SUM_W'(a_q) + SUM_W'(acc);
  assign step    = sqrt_step(rem, root, rad[RAD_W-1 -: 2]);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state  <= S_IDLE;
      a_q    <= '0;
      b_q    <= '0;
      mplr   <= '0;
      cube_q <= 1'b0;
      mcand  <= '0;
      acc    <= '0;
      rad    <= '0;
      rem    <= '0;
      root   <= '0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      y_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start_i) begin
            a_q    <= bus.a_bi;
            b_q    <= bus.b_bi;
            cube_q <= ~bus.mode_i;
            mcand  <= PROD_W'(bus.b_bi);
            mplr   <= bus.b_bi;
            acc    <= '0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= S_MUL1;
          end
        end
        S_MUL1, S_MUL2: begin
          acc   <= acc_nxt;
          mcand <= mcand << 1;
          mplr  <= mplr >> 1;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            cnt <= '0;
            // Cube: the finished square becomes the multiplicand of the second pass.
            if (state == S_MUL1 && cube_q) begin
              mcand <= acc_nxt;
              mplr  <= b_q;
              acc   <= '0;
              state <= S_MUL2;
            end else begin
              state <= S_ADD;
            end
          end
        end
        S_ADD: begin
          rad   <= RAD_W'(sum);
          rem   <= '0;
          root  <= '0;
          cnt   <= '0;
          state <= S_SQRT;
        end
        S_SQRT: begin
          rem  <= step[REM_W+Y_W-1:Y_W];
          root <= step[Y_W-1:0];
          rad  <= rad << 2;
          cnt  <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(Y_W - 1)) begin
            y_q    <= step[Y_W-1:0];
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy_o = busy_q;
  assign bus.done_o = done_q;
  assign bus.y_bo   = y_q;
endmodule
